ecpri_tx_resp: RTL



---
 rtl/ecpri_tx_resp.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ecpri_tx_resp.sv
// eCPRI Remote Memory Access (type 0x04) response frame builder.
// Streams a 16-byte header and, for reads, payload bytes fetched from local memory.
module ecpri_tx_resp #(
   parameter logic [3:0]  ECPRI_REV  = 4'h1,
   parameter logic [15:0] ELEMENT_ID = 16'h0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       send_read_resp,
   input  logic       send_write_resp,
   input  logic [7:0] rma_id,
   input  logic [7:0] dst_addr,
   input  logic [7:0] tx_payload_len,
   output logic       mem_rd_en,
   output logic [7:0] mem_rd_addr,
   input  logic [7:0] mem_rd_data,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       tx_last,
   output logic       busy,
   output logic       req_drop
);

   typedef enum logic [2:0] {IDLE, HDR, FETCH, CAPTURE, DATA} state_t;

   state_t      state_q, state_d;
   logic        is_read_q, is_read_d;
   logic [7:0]  rma_id_q, rma_id_d;
   logic [7:0]  dst_addr_q, dst_addr_d;
   logic [7:0]  len_q, len_d;
   logic [3:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]  idx_q, idx_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_valid_q, tx_valid_d;
   logic        tx_last_q, tx_last_d;
   logic        mem_rd_en_q, mem_rd_en_d;
   logic [7:0]  mem_rd_addr_q, mem_rd_addr_d;
   logic        busy_q, busy_d;
   logic        req_drop_q, req_drop_d;

   logic        xfer;
   logic        any_req;
   logic        hdr_only;

   assign xfer     = tx_valid_q && tx_ready;
   assign any_req  = send_read_resp || send_write_resp;
   assign hdr_only = !is_read_q || (len_q == 8'd0);

   function automatic logic [7:0] hdr_byte(input logic [3:0] n, input logic rd,
                                           input logic [7:0] id, input logic [7:0] addr,
                                           input logic [7:0] len);
      logic [15:0] psize;
      psize = rd ? (16'd12 + {8'd0, len}) : 16'd12;
      case (n)
         4'd0:    hdr_byte = {ECPRI_REV, 4'h0};
         4'd1:    hdr_byte = 8'h04;
         4'd2:    hdr_byte = psize[15:8];
         4'd3:    hdr_byte = psize[7:0];
         4'd4:    hdr_byte = id;
         4'd5:    hdr_byte = rd ? 8'h01 : 8'h11;
         4'd6:    hdr_byte = ELEMENT_ID[15:8];
         4'd7:    hdr_byte = ELEMENT_ID[7:0];
         4'd13:   hdr_byte = addr;
         4'd15:   hdr_byte = len;
         default: hdr_byte = 8'h00;
      endcase
   endfunction

   always_comb begin
      state_d       = state_q;
      is_read_d     = is_read_q;
      rma_id_d      = rma_id_q;
      dst_addr_d    = dst_addr_q;
      len_d         = len_q;
      byte_cnt_d    = byte_cnt_q;
      idx_d         = idx_q;
      tx_data_d     = tx_data_q;
      tx_valid_d    = tx_valid_q;
      tx_last_d     = tx_last_q;
      mem_rd_en_d   = 1'b0;
      mem_rd_addr_d = mem_rd_addr_q;
      busy_d        = busy_q;
      req_drop_d    = (state_q != IDLE) && any_req;

      case (state_q)
         IDLE: begin
            if (any_req) begin
               // A simultaneous read and write request keeps the read and reports the write lost.
               req_drop_d = send_read_resp && send_write_resp;
               is_read_d  = send_read_resp;
               rma_id_d   = rma_id;
               dst_addr_d = dst_addr;
               len_d      = tx_payload_len;
               byte_cnt_d = 4'd0;
               idx_d      = 8'd0;
               tx_data_d  = hdr_byte(4'd0, send_read_resp, rma_id, dst_addr, tx_payload_len);
               tx_valid_d = 1'b1;
               tx_last_d  = 1'b0;
               busy_d     = 1'b1;
               state_d    = HDR;
            end
         end
         HDR: begin
            if (xfer) begin
               if (byte_cnt_q == 4'd15) begin
                  tx_valid_d = 1'b0;
                  tx_last_d  = 1'b0;
                  if (hdr_only) begin
                     busy_d  = 1'b0;
                     state_d = IDLE;
                  end else begin
                     mem_rd_en_d   = 1'b1;
                     mem_rd_addr_d = dst_addr_q + idx_q;
                     state_d       = FETCH;
                  end
               end else begin
                  byte_cnt_d = byte_cnt_q + 4'd1;
                  tx_data_d  = hdr_byte(byte_cnt_q + 4'd1, is_read_q, rma_id_q, dst_addr_q, len_q);
                  tx_last_d  = (byte_cnt_q == 4'd14) && hdr_only;
               end
            end
         end
         FETCH: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            tx_data_d  = mem_rd_data;
            tx_valid_d = 1'b1;
            tx_last_d  = (idx_q == len_q - 8'd1);
            state_d    = DATA;
         end
         DATA: begin
            if (xfer) begin
               tx_valid_d = 1'b0;
               tx_last_d  = 1'b0;
               if (idx_q == len_q - 8'd1) begin
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  idx_d         = idx_q + 8'd1;
                  mem_rd_en_d   = 1'b1;
                  mem_rd_addr_d = dst_addr_q + idx_q + 8'd1;
                  state_d       = FETCH;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         is_read_q     <= 1'b0;
         rma_id_q      <= 8'd0;
         dst_addr_q    <= 8'd0;
         len_q         <= 8'd0;
         byte_cnt_q    <= 4'd0;
         idx_q         <= 8'd0;
         tx_data_q     <= 8'd0;
         tx_valid_q    <= 1'b0;
         tx_last_q     <= 1'b0;
         mem_rd_en_q   <= 1'b0;
         mem_rd_addr_q <= 8'd0;
         busy_q        <= 1'b0;
         req_drop_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         is_read_q     <= is_read_d;
         rma_id_q      <= rma_id_d;
         dst_addr_q    <= dst_addr_d;
         len_q         <= len_d;
         byte_cnt_q    <= byte_cnt_d;
         idx_q         <= idx_d;
         tx_data_q     <= tx_data_d;
         tx_valid_q    <= tx_valid_d;
         tx_last_q     <= tx_last_d;
         mem_rd_en_q   <= mem_rd_en_d;
         mem_rd_addr_q <= mem_rd_addr_d;
         busy_q        <= busy_d;
         req_drop_q    <= req_drop_d;
      end
   end

   assign mem_rd_en   = mem_rd_en_q;
   assign mem_rd_addr = mem_rd_addr_q;
   assign tx_data     = tx_data_q;
   assign tx_valid    = tx_valid_q;
   assign tx_last     = tx_last_q;
   assign busy        = busy_q;
   assign req_drop    = req_drop_q;

endmodule
